// File: rtl/edge_pkg.sv
// Shared encodings for the multi-channel edge detector: FSM state codes,
// per-channel mode codes and the mode-gating helper.
package edge_pkg;

   typedef enum logic [1:0] {
      LOW  = 2'b00,
      RISE = 2'b01,
      FALL = 2'b10,
      HIGH = 2'b11
   } state_t;

   localparam logic [1:0] OFF     = 2'b00;
   localparam logic [1:0] RISING  = 2'b01;
   localparam logic [1:0] FALLING = 2'b10;
   localparam logic [1:0] BOTH    = 2'b11;

   // Mode bit 0 enables rising-edge ticks, bit 1 enables falling-edge ticks.
   function automatic logic mode_tick(input logic [1:0] m, input logic r, input logic f);
      return (r & m[0]) | (f & m[1]);
   endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: level synchronizer, LOW/RISE/HIGH/FALL Moore FSM and
// rise/fall decode from the registered state.
module edge_chan
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state;
   state_t                 w_state_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= LOW;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A one-cycle synchronized pulse takes RISE -> FALL directly so neither edge is lost.
   always_comb begin
      w_state_next = LOW;
      case (r_state)
         LOW:     w_state_next = w_s ? RISE : LOW;
         RISE:    w_state_next = w_s ? HIGH : FALL;
         HIGH:    w_state_next = w_s ? HIGH : FALL;
         FALL:    w_state_next = w_s ? RISE : LOW;
         default: w_state_next = LOW;
      endcase
   end

   assign o_rise = (r_state == RISE);
   assign o_fall = (r_state == FALL);

endmodule

// File: rtl/edge_detector_multi.sv
// N_CH independent edge detectors with per-channel mode gating, sticky
// pending flags (set wins over clear) and a combined any_pending flag.
module edge_detector_multi
   import edge_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_CH-1:0]   level,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   rise,
   output logic [N_CH-1:0]   fall,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   pending,
   output logic              any_pending
);

   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_fall;
   logic [N_CH-1:0] w_tick;
   logic [N_CH-1:0] r_pending;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .i_level (level[gi]),
         .o_rise  (w_rise[gi]),
         .o_fall  (w_fall[gi])
      );

      // Mode is applied combinationally so a change takes effect in the same cycle.
      assign w_tick[gi] = mode_tick(mode[2*gi+1 -: 2], w_rise[gi], w_fall[gi]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~clr) | w_tick;
      end
   end

   assign rise        = w_rise;
   assign fall        = w_fall;
   assign tick        = w_tick;
   assign pending     = r_pending;
   assign any_pending = |r_pending;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed plus randomized bench for edge_detector_multi, checked every cycle
// against a level-history reference model.
module tb_edge_detector_multi;

   localparam int N_CH = 4;
   localparam int SS   = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [N_CH-1:0]   level = '0;
   logic [2*N_CH-1:0] mode = '0;
   logic [N_CH-1:0]   clr = '0;
   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   fall;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   pending;
   logic              any_pending;

   edge_detector_multi #(
      .N_CH        (N_CH),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .level       (level),
      .mode        (mode),
      .clr         (clr),
      .rise        (rise),
      .fall        (fall),
      .tick        (tick),
      .pending     (pending),
      .any_pending (any_pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model: hist[0] is the level seen at the latest edge. The FSM state after an
   // edge is fixed by the synchronized value now and one edge earlier.
   logic [N_CH-1:0] hist[$];
   logic [N_CH-1:0] exp_rise;
   logic [N_CH-1:0] exp_fall;
   logic [N_CH-1:0] exp_pend;

   function automatic logic [N_CH-1:0] tick_of(input logic [N_CH-1:0] r,
                                               input logic [N_CH-1:0] f,
                                               input logic [2*N_CH-1:0] m);
      logic [N_CH-1:0] t;
      t = '0;
      for (int c = 0; c < N_CH; c++) begin
         t[c] = (r[c] & m[2*c]) | (f[c] & m[2*c+1]);
      end
      return t;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < SS + 2; i++) hist.push_back('0);
      exp_rise = '0;
      exp_fall = '0;
      exp_pend = '0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
   endtask

   task automatic check_all(input string tag);
      logic [N_CH-1:0] exp_tick;
      exp_tick = tick_of(exp_rise, exp_fall, mode);
      check({tag, ".rise"},    32'(rise),        32'(exp_rise));
      check({tag, ".fall"},    32'(fall),        32'(exp_fall));
      check({tag, ".tick"},    32'(tick),        32'(exp_tick));
      check({tag, ".pending"}, 32'(pending),     32'(exp_pend));
      check({tag, ".any"},     32'(any_pending), 32'(|exp_pend));
   endtask

   task automatic step(input string tag);
      logic [N_CH-1:0] s_now;
      logic [N_CH-1:0] s_old;
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
         model_reset();
      end else begin
         exp_pend = (exp_pend & ~clr) | tick_of(exp_rise, exp_fall, mode);
         hist.push_front(level);
         void'(hist.pop_back());
         s_now    = hist[SS];
         s_old    = hist[SS+1];
         exp_rise = s_now & ~s_old;
         exp_fall = ~s_now & s_old;
      end
      #1;
      check_all(tag);
   endtask

   task automatic steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      int guard;
      int r_cnt;
      int f_cnt;

      model_reset();
      #1;
      check_all("reset");
      steps("reset_hold", 2);
      reset_n = 1'b1;
      mode    = 8'b01_01_01_01;
      steps("idle", 3);

      $display("scenario: ch0 rising edge latency");
      level[0] = 1'b1;
      steps("ch0_rise", 6);

      $display("scenario: ch1 one-cycle pulse, mode both");
      mode[3:2] = 2'b11;
      level[1]  = 1'b1;
      step("ch1_pulse");
      level[1]  = 1'b0;
      steps("ch1_pulse", 6);
      check("ch1_pending", 32'(pending[1]), 32'd1);

      $display("scenario: ch2 falling-only then off");
      mode[5:4] = 2'b10;
      level[2]  = 1'b1;
      steps("ch2_fall_mode", 4);
      level[2]  = 1'b0;
      steps("ch2_fall_mode", 5);
      clr = 4'b0100;
      step("ch2_clear");
      clr = '0;
      mode[5:4] = 2'b00;
      level[2]  = 1'b1;
      steps("ch2_off", 4);
      level[2]  = 1'b0;
      steps("ch2_off", 5);
      check("ch2_pending_off", 32'(pending[2]), 32'd0);

      $display("scenario: ch3 set wins over clear");
      mode[7:6] = 2'b01;
      level[3]  = 1'b1;
      guard = 0;
      do begin
         step("ch3_wait");
         guard++;
      end while (!exp_rise[3] && guard < 10);
      check("ch3_wait_bound", 32'(guard < 10), 32'd1);
      clr[3] = 1'b1;
      step("ch3_set_clr");
      check("ch3_set_wins", 32'(pending[3]), 32'd1);
      step("ch3_clr");
      check("ch3_cleared", 32'(pending[3]), 32'd0);
      clr = '0;
      steps("ch3_after", 2);

      $display("scenario: async reset during RISE");
      level[0] = 1'b0;
      steps("ch0_low", 5);
      level[0] = 1'b1;
      guard = 0;
      do begin
         step("ch0_wait");
         guard++;
      end while (!exp_rise[0] && guard < 10);
      check("ch0_rise_seen", 32'(rise[0]), 32'd1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      check("async_rst_outs", 32'({rise, fall, tick, pending, any_pending}), 32'd0);
      steps("rst_hold", 2);
      reset_n = 1'b1;
      step("post_rst1");
      check("post_rst1_rise0", 32'(rise[0]), 32'd0);
      step("post_rst2");
      check("post_rst2_rise0", 32'(rise[0]), 32'd0);
      step("post_rst3");
      check("post_rst3_rise0", 32'(rise[0]), 32'd1);
      steps("post_rst", 2);

      $display("scenario: ch0 toggling every clock");
      mode     = 8'b11_11_11_11;
      level[0] = 1'b0;
      steps("toggle_settle", 5);
      r_cnt = 0;
      f_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         if (i < 8) level[0] = ~level[0];
         step("toggle");
         r_cnt += int'(rise[0]);
         f_cnt += int'(fall[0]);
      end
      check("toggle_rise_cnt", 32'(r_cnt), 32'd4);
      check("toggle_fall_cnt", 32'(f_cnt), 32'd4);

      $display("scenario: randomized traffic");
      for (int i = 0; i < 400; i++) begin
         level = N_CH'($urandom);
         if ($urandom_range(0, 7) == 0) mode = (2*N_CH)'($urandom);
         clr = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0;
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            model_reset();
            #1;
            check_all("rand_rst");
            step("rand_rst_hold");
            reset_n = 1'b1;
         end
         step("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per channel (2..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 level  input  N_CH  asynchronous level inputs, one bit per channel.
REQ-006 mode  input  2*N_CH  per-channel select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 clr  input  N_CH  per-channel clear of the pending flag, synchronous, active-high.
REQ-008 rise  output  N_CH  one-cycle pulse per detected rising edge, independent of mode.
REQ-009 fall  output  N_CH  one-cycle pulse per detected falling edge, independent of mode.
REQ-010 tick  output  N_CH  one-cycle pulse per edge enabled by mode.
REQ-011 pending  output  N_CH  sticky flag, set by tick, cleared by clr.
REQ-012 any_pending  output  1  OR of all pending bits.

Function
REQ-013 Each channel SHALL pass level[i] through a SYNC_STAGES-deep flop chain; s[i] is the last stage.
REQ-014 Each channel SHALL run a 4-state Moore FSM: LOW, RISE, HIGH, FALL.
REQ-015 LOW: s=1 -> RISE, else LOW.
REQ-016 RISE: s=1 -> HIGH, else FALL.
REQ-017 HIGH: s=0 -> FALL, else HIGH.
REQ-018 FALL: s=1 -> RISE, else LOW.
REQ-019 Illegal or unused encodings SHALL go to LOW on the next clock.
REQ-020 rise[i] SHALL be 1 exactly while the state is RISE; fall[i] SHALL be 1 exactly while the state is FALL. Both are decoded from the registered state only.
REQ-021 tick[i] SHALL equal (rise[i] & mode[2i]) | (fall[i] & mode[2i+1]). A mode change therefore applies in the same cycle.
REQ-022 Latency SHALL be SYNC_STAGES+1 clocks: level stable high before edge k gives rise=1 in the cycle after edge k+SYNC_STAGES.
REQ-023 A synchronized pulse exactly 1 cycle wide SHALL produce RISE then FALL on consecutive cycles, so no edge is lost.
REQ-024 Toggling s every cycle SHALL alternate RISE and FALL with no LOW or HIGH in between.
REQ-025 pending[i] SHALL be set on the clock where tick[i]=1, cleared on the clock where clr[i]=1, and otherwise held.
REQ-026 If tick[i] and clr[i] are both 1 on the same clock, pending[i] SHALL end at 1 (set wins).
REQ-027 Mode 00 SHALL suppress tick and pending-set but SHALL NOT stop the FSM, rise, or fall.
REQ-028 Channels SHALL be fully independent; no cross-channel interaction except any_pending.
REQ-029 any_pending SHALL be combinational from the pending register.

Reset
REQ-030 reset_n=0 SHALL immediately clear all synchronizer flops and pending, and force every FSM to LOW. rise, fall, tick and any_pending are then 0.
REQ-031 Reset assertion mid-operation, including during RISE or FALL, SHALL drop all outputs to 0 asynchronously with no residual pulse.
REQ-032 Deassertion is synchronous to clk by system convention. A level already high at deassertion SHALL be reported as a rising edge after SYNC_STAGES+1 clocks.

Structure
REQ-033 Package edge_pkg SHALL hold the 2-bit state encoding (LOW=00, RISE=01, HIGH=11, FALL=10) and the mode constants (OFF, RISING, FALLING, BOTH).
REQ-034 Sub-module edge_chan SHALL contain one channel (synchronizer, FSM, rise/fall decode). The top instantiates it N_CH times via generate and holds the mode gating, pending register and any_pending.

Verification
REQ-035 N_CH=4, SYNC_STAGES=2, mode=all 01; level[0] 0->1 before edge 10 -> rise[0]=tick[0]=1 only in the cycle after edge 12; pending[0]=1 from edge 13; other channels stay 0.
REQ-036 level[1] high for one clock (synchronously driven), mode ch1=11 -> rise[1] one cycle, fall[1] the next cycle, two ticks; pending[1]=1.
REQ-037 mode ch2=10, level[2] 0->1->0 -> rise[2] pulses with tick[2]=0; tick[2]=1 only on fall; mode ch2=00 on a repeat -> rise and fall pulse, tick=0, pending unchanged.
REQ-038 clr[3]=1 on the same edge tick[3] sets -> pending[3]=1; clr[3]=1 on the next edge with no tick -> pending[3]=0; any_pending tracks the OR.
REQ-039 reset_n=0 asserted while ch0 is in RISE -> all outputs 0 with no clock; level[0] held 1 through deassertion -> rise[0] pulses 3 clocks after deassertion.
REQ-040 level[0] toggled every clock for 8 clocks -> rise and fall alternate each cycle; rise count = fall count = 4 (±1 at the boundary).
